// File: rtl/seg7_bcd_scan_ctrl.sv
// Eight-digit seven-segment controller: sequential double-dabble binary-to-BCD conversion,
// atomic commit, and time-multiplexed scan with leading-zero blanking and overflow dashes.
module seg7_bcd_scan_ctrl #(
    parameter int unsigned w_value     = 16,
    parameter int unsigned w_digit     = 8,
    parameter int unsigned n_show      = 4,
    parameter int unsigned scan_period = 50000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [w_value-1:0] value_i,
    input  logic               value_valid_i,
    output logic               value_ready_o,
    input  logic               display_en_i,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [7:0]         abcdefgh_o,
    output logic [w_digit-1:0] digit_o
);

    localparam int unsigned BcdW  = 20;
    localparam int unsigned DispW = 4 * n_show;
    localparam int unsigned CntW  = $clog2(w_value + 1);
    localparam int unsigned SelW  = (n_show > 1) ? $clog2(n_show) : 1;
    localparam int unsigned TickW = $clog2(scan_period);

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e             state_q;
    logic [w_value-1:0] bin_q;
    logic [BcdW-1:0]    bcd_q;
    logic [BcdW-1:0]    bcd_adj;
    logic [CntW-1:0]    cnt_q;
    logic [DispW-1:0]   disp_q;
    logic               ovf_q, ovf_d;
    logic               ready_q, busy_q;

    logic [TickW-1:0]   tick_q;
    logic [SelW-1:0]    sel_q;
    logic [w_digit-1:0] digit_q;
    logic [7:0]         seg_q, seg_d, seg_code;
    logic [3:0]         nib;
    logic               lead_zero, blank;

    // Add-3 correction on every nibble, applied before the shift in the same cycle.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        ovf_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= int'(n_show) && bcd_q[4*i +: 4] != 4'd0) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (value_valid_i) begin
                        bin_q   <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= CntW'(w_value);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    disp_q  <= bcd_q[DispW-1:0];
                    ovf_q   <= ovf_d;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A digit above 0 is blank when it and every higher shown digit are zero.
    always_comb begin
        nib       = 4'd0;
        lead_zero = 1'b1;
        for (int i = 0; i < int'(n_show); i++) begin
            if (SelW'(i) == sel_q) begin
                nib = disp_q[4*i +: 4];
            end
            if (i >= int'(sel_q) && disp_q[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        blank = lead_zero && (sel_q != '0);
    end

    always_comb begin
        case (nib)
            4'd0:    seg_code = 8'hFC;
            4'd1:    seg_code = 8'h60;
            4'd2:    seg_code = 8'hDA;
            4'd3:    seg_code = 8'hF2;
            4'd4:    seg_code = 8'h66;
            4'd5:    seg_code = 8'hB6;
            4'd6:    seg_code = 8'hBE;
            4'd7:    seg_code = 8'hE0;
            4'd8:    seg_code = 8'hFE;
            4'd9:    seg_code = 8'hF6;
            default: seg_code = 8'h00;
        endcase
        if (ovf_q) begin
            seg_d = 8'h02;
        end else if (blank) begin
            seg_d = 8'h00;
        end else begin
            seg_d = seg_code;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            sel_q   <= '0;
            digit_q <= w_digit'(1);
            seg_q   <= 8'hFC;
        end else begin
            if (tick_q == TickW'(scan_period - 1)) begin
                tick_q <= '0;
                sel_q  <= (sel_q == SelW'(n_show - 1)) ? '0 : sel_q + SelW'(1);
            end else begin
                tick_q <= tick_q + TickW'(1);
            end
            // Blanking only gates the pins; the scan position keeps moving.
            if (display_en_i) begin
                digit_q <= w_digit'(1) << sel_q;
                seg_q   <= seg_d;
            end else begin
                digit_q <= '0;
                seg_q   <= 8'h00;
            end
        end
    end

    assign value_ready_o = ready_q;
    assign busy_o        = busy_q;
    assign overflow_o    = ovf_q;
    assign abcdefgh_o    = seg_q;
    assign digit_o       = digit_q;

endmodule
